ws2812_pixel_feeder: RTL and testbench

//  Upstream stage of the WS2812 serializer. Holds an LED_NUM x 24-bit pixel RAM written by the host.

---
 rtl/ws2812_pixel_feeder.sv | 216 +++++++++++++++++++++
 tb/tb_ws2812_pixel_feeder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_pixel_feeder.sv
// ---------------------------------------------------------------------------
// ws2812_pixel_feeder
//   Upstream stage of the WS2812 serializer. Holds an LED_NUM x 24-bit pixel
//   RAM written by the host and streams one frame of pixels (index 0 first)
//   over a valid/ready handshake. A frame starts on an internal refresh tick
//   or on a host frame_req pulse. Host RGB is reordered to WS2812 wire order
//   GRB; the serializer shifts pix_data MSB (bit 23) first.
//
// Optional feature macro: WS2812_GAMMA_EN
//   Defined   : each 8-bit channel passes a 2.2 gamma ROM, adding one
//               register stage (state GAMMA) between FETCH and PRESENT.
//   Undefined : channels pass through unmodified.
//
// Parameters
//   LED_NUM     number of LEDs in the chain (>=1)
//   CLK_FRE     clk frequency in Hz
//   REFRESH_HZ  auto-refresh rate; 0 disables the refresh timer
//
// Ports
//   clk         system clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   wr_en       host pixel write strobe
//   wr_addr     LED index to write (>= LED_NUM is ignored)
//   wr_data     {R,G,B}
//   frame_req   1-cycle request to send a frame now
//   pix_valid   pix_data/pix_last valid toward serializer
//   pix_ready   serializer accepts the current pixel
//   pix_data    {G,R,B} of current LED
//   pix_last    current pixel is index LED_NUM-1
//   frame_busy  frame in progress (FETCH..DONE)
//   frame_done  1-cycle pulse after the last pixel transfer
// ---------------------------------------------------------------------------
module ws2812_pixel_feeder #(
    parameter int  LED_NUM    = 16,
    parameter int  CLK_FRE    = 27_000_000,
    parameter int  REFRESH_HZ = 30,
    localparam int AW         = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          frame_req,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [23:0]   pix_data,
    output logic          pix_last,
    output logic          frame_busy,
    output logic          frame_done
);

    localparam logic [AW-1:0] LAST = AW'(LED_NUM - 1);

`ifdef WS2812_GAMMA_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        GAMMA   = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;
`endif

    state_t        state;
    logic [AW-1:0] index;
    logic          pending;
    logic          tick;
    logic          request;
    logic [23:0]   ram [LED_NUM];
    logic [23:0]   rd_q;
    logic [23:0]   pix_src;

    // ------------------------------------------------------------------
    // Refresh timer: free-running, the wrap cycle is the tick.
    // ------------------------------------------------------------------
    if (REFRESH_HZ > 0) begin : g_refresh
        localparam int PERIOD = (CLK_FRE / REFRESH_HZ > 1) ? CLK_FRE / REFRESH_HZ : 1;
        localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
        localparam logic [CW-1:0] WRAP = CW'(PERIOD - 1);
        logic [CW-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (cnt == WRAP)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end

        assign tick = (cnt == WRAP);
    end else begin : g_no_refresh
        assign tick = 1'b0;
    end

    // Tick and frame_req in the same cycle collapse into one request.
    assign request = tick | frame_req;

    // ------------------------------------------------------------------
    // Pixel RAM. No reset so it maps onto block RAM; contents survive
    // rst_n. Read and write share the edge, so a same-address collision
    // returns the old word (read-first).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < LED_NUM))
            ram[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_q <= '0;
        else if (state == FETCH)
            rd_q <= ram[index];
    end

`ifdef WS2812_GAMMA_EN
    // out = round(255 * (in/255)^2.2), folded to constants at elaboration.
    logic [7:0]  gamma_rom [256];
    logic [23:0] gam_q;

    for (genvar g = 0; g < 256; g++) begin : g_gamma
        localparam real NORM = g / 255.0;
        localparam int  VAL  = $rtoi(255.0 * (NORM ** 2.2) + 0.5);
        assign gamma_rom[g] = 8'(VAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gam_q <= '0;
        else if (state == GAMMA)
            gam_q <= {gamma_rom[rd_q[23:16]], gamma_rom[rd_q[15:8]], gamma_rom[rd_q[7:0]]};
    end

    assign pix_src = gam_q;
`else
    assign pix_src = rd_q;
`endif

    // Source register only loads in FETCH/GAMMA, so data is stable in PRESENT.
    assign pix_data = {pix_src[15:8], pix_src[23:16], pix_src[7:0]};

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= '0;
            pending    <= 1'b0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // One-deep request memory; extra requests merge into it.
            if (request && state != IDLE)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (request || pending) begin
                        state      <= FETCH;
                        pending    <= 1'b0;
                        index      <= '0;
                        frame_busy <= 1'b1;
                    end
                end
                FETCH: begin
`ifdef WS2812_GAMMA_EN
                    state     <= GAMMA;
`else
                    state     <= PRESENT;
                    pix_valid <= 1'b1;
                    pix_last  <= (index == LAST);
`endif
                end
`ifdef WS2812_GAMMA_EN
                GAMMA: begin
                    state     <= PRESENT;
                    pix_valid <= 1'b1;
                    pix_last  <= (index == LAST);
                end
`endif
                PRESENT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                        if (index == LAST) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            index <= index + AW'(1);
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    frame_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// ---------------------------------------------------------------------------
// tb_ws2812_pixel_feeder
//   Directed bench for ws2812_pixel_feeder (default build, gamma off).
//   dut  : LED_NUM=16, refresh timer off -> frames only on frame_req.
//   dut2 : LED_NUM=3, CLK_FRE=10 MHz, REFRESH_HZ=1 MHz -> tick every 10 cycles.
// ---------------------------------------------------------------------------
module tb_ws2812_pixel_feeder;

    localparam int N  = 16;
    localparam int N2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut
    logic        rst_n, wr_en, frame_req, pix_ready;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic        pix_valid, pix_last, frame_busy, frame_done;
    logic [23:0] pix_data;

    // dut2
    logic        rst2_n, wr2_en, frame2_req, pix2_ready;
    logic [1:0]  wr2_addr;
    logic [23:0] wr2_data;
    logic        pix2_valid, pix2_last, frame2_busy, frame2_done;
    logic [23:0] pix2_data;

    ws2812_pixel_feeder #(.LED_NUM(N), .CLK_FRE(27_000_000), .REFRESH_HZ(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_req(frame_req), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last), .frame_busy(frame_busy),
        .frame_done(frame_done)
    );

    ws2812_pixel_feeder #(.LED_NUM(N2), .CLK_FRE(10_000_000), .REFRESH_HZ(1_000_000)) dut2 (
        .clk(clk), .rst_n(rst2_n), .wr_en(wr2_en), .wr_addr(wr2_addr), .wr_data(wr2_data),
        .frame_req(frame2_req), .pix_valid(pix2_valid), .pix_ready(pix2_ready),
        .pix_data(pix2_data), .pix_last(pix2_last), .frame_busy(frame2_busy),
        .frame_done(frame2_done)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [23:0] mem  [N];
    logic [23:0] mem2 [N2];

    function automatic logic [23:0] grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        step();
        wr_en = 1'b0;
        mem[a] = d;
    endtask

    task automatic wr2(input int a, input logic [23:0] d);
        wr2_en = 1'b1; wr2_addr = 2'(a); wr2_data = d;
        step();
        wr2_en = 1'b0;
        if (a < N2) mem2[a] = d;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 6 && !pix_valid; k++) step();
        chk({tag, "_valid"}, 32'(pix_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int k = 0; k < bound && !frame_done; k++) step();
        chk({tag, "_done"}, 32'(frame_done), 32'd1);
    endtask

    // Full frame with pix_ready high; optionally write LED wr_at during its FETCH.
    task automatic run_frame(input string tag, input int wr_at, input logic [23:0] wv);
        pix_ready = 1'b1;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        chk({tag, "_busy"}, 32'(frame_busy), 32'd1);
        for (int p = 0; p < N; p++) begin
            wait_valid(tag);
            chk($sformatf("%s_data%0d", tag, p), 32'(pix_data), 32'(grb(mem[p])));
            chk($sformatf("%s_last%0d", tag, p), 32'(pix_last), 32'(p == N - 1));
            if (p + 1 == wr_at) begin
                step();
                wr_en = 1'b1; wr_addr = 4'(wr_at); wr_data = wv;
                step();
                wr_en = 1'b0;
            end else begin
                step();
            end
        end
        chk({tag, "_done_hi"}, 32'(frame_done), 32'd1);
        step();
        chk({tag, "_done_lo"}, 32'(frame_done), 32'd0);
        chk({tag, "_idle"}, 32'(frame_busy), 32'd0);
        if (wr_at >= 0) mem[wr_at] = wv;
    endtask

    task automatic find_rise2(output int t);
        logic prev;
        prev = frame2_busy;
        t = -1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (!prev && frame2_busy) begin
                t = cyc;
                break;
            end
            prev = frame2_busy;
        end
        chk("tick_rise_found", 32'(t >= 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [23:0] held;
        int          t1, t2, cnt;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; frame_req = 1'b0; pix_ready = 1'b0;
        rst2_n = 1'b0; wr2_en = 1'b0; wr2_addr = '0; wr2_data = '0; frame2_req = 1'b0; pix2_ready = 1'b1;
        step(); step();

        // Reset state
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_data",  32'(pix_data),  32'd0);
        chk("rst_last",  32'(pix_last),  32'd0);
        chk("rst_busy",  32'(frame_busy), 32'd0);
        chk("rst_done",  32'(frame_done), 32'd0);
        rst_n = 1'b1;
        rst2_n = 1'b1;

        // Preload RAM
        for (int i = 0; i < N; i++) wr(i, {8'(i), 8'(8'h10 + i), 8'(8'h20 + i)});
        wr(0, 24'hFF0000);
        wr(1, 24'h00FF00);
        for (int i = 0; i < N2; i++) wr2(i, {8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i)});
        wr2(3, 24'hFFFFFF);   // out of range, must be dropped

        // No timer on dut: stays idle without a request
        repeat (4) step();
        chk("no_req_idle", 32'(frame_busy), 32'd0);

        // Basic frame: LED0 -> 00FF00, LED1 -> FF0000
        run_frame("f1", -1, 24'h0);
        chk("f1_led0_lit", 32'(grb(mem[0])), 32'h00FF00);

        // Back-pressure: hold for 10 cycles, then exactly one transfer
        pix_ready = 1'b0;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        chk("stall_valid0", 32'(pix_valid), 32'd1);
        held = grb(mem[0]);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("stall_valid_%0d", k), 32'(pix_valid), 32'd1);
            chk($sformatf("stall_data_%0d", k), 32'(pix_data), 32'(held));
        end
        pix_ready = 1'b1;
        step();
        chk("stall_xfer_drop", 32'(pix_valid), 32'd0);
        step();
        chk("stall_next_valid", 32'(pix_valid), 32'd1);
        chk("stall_next_data", 32'(pix_data), 32'(grb(mem[1])));
        wait_done("stall", 80);
        step();

        // Read-first collision on LED3, then the new value in the next frame
        run_frame("rdfirst", 3, 24'hABCDEF);
        run_frame("rdnew", -1, 24'h0);

        // Requests during a frame merge into one pending frame
        pix_ready = 1'b0;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        frame_req = 1'b1; step(); frame_req = 1'b0; step();
        frame_req = 1'b1; step(); frame_req = 1'b0;
        pix_ready = 1'b1;
        wait_done("pend1", 80);
        step();
        chk("pend_idle_gap", 32'(frame_busy), 32'd0);
        step();
        chk("pend_restart", 32'(frame_busy), 32'd1);
        wait_done("pend2", 80);
        step();
        repeat (5) step();
        chk("pend_only_one", 32'(frame_busy), 32'd0);

        // Asynchronous reset at index 5
        pix_ready = 1'b1;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (pix_valid) begin
                if (cnt == 5) break;
                cnt++;
            end
            step();
        end
        chk("arst_at_idx5", 32'(cnt), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(pix_valid), 32'd0);
        chk("arst_data",  32'(pix_data),  32'd0);
        chk("arst_last",  32'(pix_last),  32'd0);
        chk("arst_busy",  32'(frame_busy), 32'd0);
        chk("arst_done",  32'(frame_done), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("arst_no_done", 32'(frame_done), 32'd0);
        chk("arst_stays_idle", 32'(frame_busy), 32'd0);
        run_frame("post_rst", -1, 24'h0);

        // dut2: tick period of 10 cycles
        find_rise2(t1);
        find_rise2(t2);
        chk("tick_period", 32'(t2 - t1), 32'd10);
        for (int p = 0; p < N2; p++) begin
            for (int k = 0; k < 6 && !pix2_valid; k++) step();
            chk($sformatf("t2_valid%0d", p), 32'(pix2_valid), 32'd1);
            chk($sformatf("t2_data%0d", p), 32'(pix2_data), 32'(grb(mem2[p])));
            chk($sformatf("t2_last%0d", p), 32'(pix2_last), 32'(p == N2 - 1));
            step();
        end

        // dut2: ticks during a long frame leave one pending frame
        find_rise2(t1);
        pix2_ready = 1'b0;
        repeat (25) step();
        pix2_ready = 1'b1;
        for (int k = 0; k < 40 && !frame2_done; k++) step();
        chk("tick_pend_done", 32'(frame2_done), 32'd1);
        step();
        chk("tick_pend_idle", 32'(frame2_busy), 32'd0);
        step();
        chk("tick_pend_start", 32'(frame2_busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
